// File: rtl/program_loader.sv
// program_loader
//
// Loads a program image into the MC14500B text RAM while the core is held in
// reset. Instruction words arrive on a valid/ready stream. They are written to
// consecutive RAM addresses starting at 0. The unused tail of the RAM is then
// zero-filled with NOP0. The core stays in reset for HOLD_CYCLES further
// cycles, is released, and a one-cycle done pulse is raised.
//
// Ports:
//   clk, reset            - rising-edge clock, asynchronous active-high reset
//   load_start            - starts a load; only sampled while idle
//   word_valid/word_ready - stream handshake; a word is taken when both are high
//   word_data/word_last   - instruction word {opcode, address}; final-word flag
//   prog_write/addr/data  - registered text RAM write port
//   core_reset            - registered; holds the PC and ICU in reset
//   busy                  - high whenever the loader is not idle
//   done                  - one-cycle pulse when the core is released
//   error                 - sticky overflow flag; cleared by the next load_start
//   word_count            - words accepted in the current or most recent load
module program_loader #(
  parameter int ADDR_WIDTH        = 8,
  parameter int INSTRUCTION_WIDTH = 4,
  parameter int DATA_WIDTH        = ADDR_WIDTH + INSTRUCTION_WIDTH,
  parameter int HOLD_CYCLES       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  word_valid,
  output logic                  word_ready,
  input  logic [DATA_WIDTH-1:0] word_data,
  input  logic                  word_last,
  output logic                  prog_write,
  output logic [ADDR_WIDTH-1:0] prog_addr,
  output logic [DATA_WIDTH-1:0] prog_data,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_MAX   = '1;
  localparam logic [HOLD_W-1:0]     HOLD_INIT = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(1);
  // NOP0 is opcode 0 with address 0.
  localparam logic [DATA_WIDTH-1:0] NOP0 =
    DATA_WIDTH'({{INSTRUCTION_WIDTH{1'b0}}, {ADDR_WIDTH{1'b0}}});

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FILL,
    RELEASE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]     word_count_q, word_count_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic                    prog_write_q, prog_write_d;
  logic [ADDR_WIDTH-1:0]   prog_addr_q, prog_addr_d;
  logic [DATA_WIDTH-1:0]   prog_data_q, prog_data_d;
  logic                    core_reset_q, core_reset_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  // The stream is only accepted in LOAD, so ready is a pure decode of state.
  assign word_ready = (state_q == LOAD);
  assign busy       = (state_q != IDLE);

  assign prog_write = prog_write_q;
  assign prog_addr  = prog_addr_q;
  assign prog_data  = prog_data_q;
  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    word_count_d = word_count_q;
    hold_d       = hold_q;
    prog_write_d = 1'b0;
    prog_addr_d  = prog_addr_q;
    prog_data_d  = prog_data_q;
    core_reset_d = core_reset_q;
    done_d       = 1'b0;
    error_d      = error_q;

    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d      = LOAD;
          ptr_d        = '0;
          word_count_d = '0;
          error_d      = 1'b0;
          core_reset_d = 1'b1;
        end
      end

      LOAD: begin
        if (word_valid) begin
          prog_write_d = 1'b1;
          prog_addr_d  = ptr_q;
          prog_data_d  = word_data;
          ptr_d        = ptr_q + 1'b1;
          word_count_d = word_count_q + 1'b1;
          // Writing the top address ends the load. The RAM is full, so no
          // fill is needed. If the host had more words to send, flag overflow.
          if (ptr_q == PTR_MAX) begin
            if (!word_last) begin
              error_d = 1'b1;
            end
            state_d = RELEASE;
            hold_d  = HOLD_INIT;
          end else if (word_last) begin
            state_d = FILL;
          end
        end
      end

      FILL: begin
        prog_write_d = 1'b1;
        prog_addr_d  = ptr_q;
        prog_data_d  = NOP0;
        ptr_d        = ptr_q + 1'b1;
        if (ptr_q == PTR_MAX) begin
          state_d = RELEASE;
          hold_d  = HOLD_INIT;
        end
      end

      RELEASE: begin
        // The counter is loaded with HOLD_CYCLES on entry. Leaving when it
        // reads 1 keeps the core in reset for exactly HOLD_CYCLES cycles.
        if (hold_q == HOLD_LAST) begin
          state_d      = IDLE;
          core_reset_d = 1'b0;
          done_d       = 1'b1;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end

      default: begin
        state_d      = IDLE;
        core_reset_d = 1'b0;
      end
    endcase
  end

  // A reset in the middle of a load drops core_reset immediately, so the core
  // runs whatever partial image is in the RAM. The host must reload it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      word_count_q <= '0;
      hold_q       <= '0;
      prog_write_q <= 1'b0;
      prog_addr_q  <= '0;
      prog_data_q  <= '0;
      core_reset_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      word_count_q <= word_count_d;
      hold_q       <= hold_d;
      prog_write_q <= prog_write_d;
      prog_addr_q  <= prog_addr_d;
      prog_data_q  <= prog_data_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader. It uses a 16-entry text RAM
// (ADDR_WIDTH=4), 8-bit words and a hold time of 4 cycles.
module tb_program_loader;

  localparam int AW   = 4;
  localparam int IW   = 4;
  localparam int DW   = AW + IW;
  localparam int HOLD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start;
  logic          word_valid;
  logic          word_ready;
  logic [DW-1:0] word_data;
  logic          word_last;
  logic          prog_write;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;
  logic          core_reset;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   word_count;

  int errors   = 0;
  int checks   = 0;
  int wr_count = 0;
  logic [DW-1:0] mem [16];

  // Stalled-stream vectors. The third word carries last. A load_start pulse
  // is made during the stall after the second word and must be ignored.
  logic          stall_valid [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic          stall_last  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic          stall_start [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [DW-1:0] stall_data  [6] = '{8'h12, 8'hFF, 8'hFF, 8'h45, 8'hEE, 8'h78};

  program_loader #(
    .ADDR_WIDTH       (AW),
    .INSTRUCTION_WIDTH(IW),
    .DATA_WIDTH       (DW),
    .HOLD_CYCLES      (HOLD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_start(load_start),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .word_data (word_data),
    .word_last (word_last),
    .prog_write(prog_write),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .core_reset(core_reset),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Capture every RAM write into a shadow memory, away from the active edge.
  always @(negedge clk) begin
    if (prog_write === 1'b1) begin
      mem[prog_addr] = prog_data;
      wr_count++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic valid,
                               input logic last, input logic [DW-1:0] data);
    load_start = start;
    word_valid = valid;
    word_last  = last;
    word_data  = data;
    step();
    load_start = 1'b0;
    word_valid = 1'b0;
    word_last  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearMem();
    for (int i = 0; i < 16; i++) mem[i] = 8'hAA;
    wr_count = 0;
  endtask

  initial begin
    int n;
    int cyc;
    reset      = 1'b1;
    load_start = 1'b0;
    word_valid = 1'b0;
    word_last  = 1'b0;
    word_data  = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    checkOutput("rst_busy",       32'(busy),       32'd0);
    checkOutput("rst_core_reset", 32'(core_reset), 32'd0);
    checkOutput("rst_word_ready", 32'(word_ready), 32'd0);
    checkOutput("rst_prog_write", 32'(prog_write), 32'd0);
    checkOutput("rst_done",       32'(done),       32'd0);
    checkOutput("rst_error",      32'(error),      32'd0);
    checkOutput("rst_word_count", 32'(word_count), 32'd0);
    checkOutput("rst_prog_addr",  32'(prog_addr),  32'd0);
    checkOutput("rst_prog_data",  32'(prog_data),  32'd0);
    reset = 1'b0;
    step();

    // Three-word load with a stalled stream
    $display("[TB] three-word stalled load");
    clearMem();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("start_busy",       32'(busy),       32'd1);
    checkOutput("start_core_reset", 32'(core_reset), 32'd1);
    checkOutput("start_word_ready", 32'(word_ready), 32'd1);
    checkOutput("start_prog_write", 32'(prog_write), 32'd0);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(stall_start[k], stall_valid[k], stall_last[k], stall_data[k]);
      if (stall_valid[k]) n++;
      checkOutput("stall_write", 32'(prog_write), 32'(stall_valid[k]));
      checkOutput("stall_count", 32'(word_count), 32'(n));
      if (stall_valid[k]) begin
        checkOutput("stall_addr", 32'(prog_addr), 32'(n - 1));
        checkOutput("stall_data", 32'(prog_data), 32'(stall_data[k]));
      end
    end
    for (int i = 3; i < 16; i++) begin
      step();
      checkOutput("fill_write", 32'(prog_write), 32'd1);
      checkOutput("fill_addr",  32'(prog_addr),  32'(i));
      checkOutput("fill_data",  32'(prog_data),  32'd0);
      checkOutput("fill_ready", 32'(word_ready), 32'd0);
      checkOutput("fill_core",  32'(core_reset), 32'd1);
    end
    for (int j = 0; j < HOLD - 1; j++) begin
      step();
      checkOutput("hold_write", 32'(prog_write), 32'd0);
      checkOutput("hold_core",  32'(core_reset), 32'd1);
      checkOutput("hold_done",  32'(done),       32'd0);
      checkOutput("hold_busy",  32'(busy),       32'd1);
    end
    step();
    checkOutput("rel_done",  32'(done),       32'd1);
    checkOutput("rel_core",  32'(core_reset), 32'd0);
    checkOutput("rel_busy",  32'(busy),       32'd0);
    checkOutput("rel_count", 32'(word_count), 32'd3);
    checkOutput("rel_error", 32'(error),      32'd0);
    step();
    checkOutput("done_pulse", 32'(done), 32'd0);
    checkOutput("img_w0", 32'(mem[0]), 32'h12);
    checkOutput("img_w1", 32'(mem[1]), 32'h45);
    checkOutput("img_w2", 32'(mem[2]), 32'h78);
    for (int i = 3; i < 16; i++) checkOutput("img_fill", 32'(mem[i]), 32'd0);
    checkOutput("img_writes", 32'(wr_count), 32'd16);

    // Full image: no fill, straight to release
    $display("[TB] full image");
    clearMem();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, (i == 15), DW'(8'h30 + i));
    end
    checkOutput("full_count", 32'(word_count), 32'd16);
    checkOutput("full_error", 32'(error),      32'd0);
    step();
    checkOutput("full_nofill", 32'(prog_write), 32'd0);
    checkOutput("full_core",   32'(core_reset), 32'd1);
    for (int j = 0; j < HOLD - 2; j++) begin
      step();
      checkOutput("full_hold", 32'(done), 32'd0);
    end
    step();
    checkOutput("full_done", 32'(done), 32'd1);
    for (int i = 0; i < 16; i++) checkOutput("full_img", 32'(mem[i]), 32'(8'h30 + i));
    checkOutput("full_writes", 32'(wr_count), 32'd16);

    // Overflow: last never set
    $display("[TB] overflow");
    clearMem();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, DW'(8'hC0 + i));
    end
    checkOutput("ovf_error", 32'(error),      32'd1);
    checkOutput("ovf_count", 32'(word_count), 32'd16);
    for (int j = 0; j < HOLD - 1; j++) step();
    checkOutput("ovf_pre_done", 32'(done), 32'd0);
    step();
    checkOutput("ovf_done",        32'(done),  32'd1);
    checkOutput("ovf_error_done",  32'(error), 32'd1);
    step();
    checkOutput("ovf_error_stick", 32'(error), 32'd1);
    checkOutput("ovf_writes",      32'(wr_count), 32'd16);
    checkOutput("ovf_last_word",   32'(mem[15]), 32'hCF);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("ovf_clear_error", 32'(error),      32'd0);
    checkOutput("ovf_clear_count", 32'(word_count), 32'd0);
    checkOutput("ovf_clear_busy",  32'(busy),       32'd1);

    // Reset in the middle of FILL
    $display("[TB] reset mid-fill");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h99);
    checkOutput("mid_addr0", 32'(prog_addr), 32'd0);
    step();
    step();
    checkOutput("mid_fill_write", 32'(prog_write), 32'd1);
    checkOutput("mid_fill_addr",  32'(prog_addr),  32'd2);
    reset = 1'b1;
    #1;
    checkOutput("arst_write", 32'(prog_write), 32'd0);
    checkOutput("arst_core",  32'(core_reset), 32'd0);
    checkOutput("arst_busy",  32'(busy),       32'd0);
    checkOutput("arst_ready", 32'(word_ready), 32'd0);
    checkOutput("arst_count", 32'(word_count), 32'd0);
    #1;
    reset = 1'b0;
    step();
    checkOutput("arst_idle", 32'(busy), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h5A);
    checkOutput("reload_addr",  32'(prog_addr),  32'd0);
    checkOutput("reload_data",  32'(prog_data),  32'h5A);
    checkOutput("reload_count", 32'(word_count), 32'd1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
    checkOutput("reload_done",    32'(done), 32'd1);
    checkOutput("reload_latency", 32'(cyc),  32'(15 + HOLD));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
